// File: rtl/regfile_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_cmd_ctrl
//
// Command sequencer that sits between the UART receive path and the register
// file. Incoming bytes are parsed into write frames (CMD_WR, addr, data) and
// read frames (CMD_RD, addr). Writes become a single-cycle rf_wr_en pulse.
// Reads become a single-cycle rf_rd_en pulse. The returned word is offered on
// a valid/ready transmit handshake. Illegal addresses, unknown opcodes,
// stalled frames and bytes that arrive while the controller cannot take them
// are reported as single-cycle err_valid pulses with an err_code.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_data      received byte
//   rx_valid     one-cycle strobe qualifying rx_data (no backpressure)
//   rf_address   register-file address
//   rf_wr_data   register-file write data
//   rf_wr_en     register-file write enable (one cycle per write frame)
//   rf_rd_en     register-file read enable (one cycle per read frame)
//   rf_rd_data   registered read data from the register file
//   rf_rd_valid  read-data valid level from the register file
//   tx_data      read result towards the transmitter
//   tx_valid     tx_data valid, held until tx_ready
//   tx_ready     transmitter accepts tx_data
//   busy         high whenever the controller is not idle
//   err_valid    one-cycle error strobe
//   err_code     00 overrun, 01 bad opcode, 10 bad address, 11 timeout
// ---------------------------------------------------------------------------
module regfile_cmd_ctrl #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 8,
  parameter int               ADDR    = 4,
  parameter int               TIMEOUT = 255,
  parameter logic [WIDTH-1:0] CMD_WR  = 8'hAA,
  parameter logic [WIDTH-1:0] CMD_RD  = 8'hBB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic [ADDR-1:0]  rf_address,
  output logic [WIDTH-1:0] rf_wr_data,
  output logic             rf_wr_en,
  output logic             rf_rd_en,
  input  logic [WIDTH-1:0] rf_rd_data,
  input  logic             rf_rd_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             err_valid,
  output logic [1:0]       err_code
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_ADDRESS = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_EXEC,
    RD_ADDR,
    RD_REQ,
    RD_WAIT,
    TX
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             drop;
  logic             tmo_hit;
  logic             addr_bad;

  // The idle counter is about to reach TIMEOUT on this edge, and the incoming
  // byte addresses a location outside the register file.
  assign tmo_hit  = (tmo_cnt == CNT_LAST);
  assign addr_bad = (rx_data >= DEPTH_W);

  // Whole controller in one registered process. Enables and the error strobe
  // default low every cycle, so each one is a single-cycle pulse.
  // The timeout counter defaults to zero. It advances only in the waiting
  // states when nothing arrives, so any accepted byte or state change clears it.
  // Errors that can coincide (overrun with bad address in WR_EXEC, overrun
  // with timeout in RD_WAIT) are written overrun-first. The later assignment
  // of the higher code then takes effect.
  // The enables go high on the edge that leaves WR_EXEC / RD_REQ. A reset
  // sampled on that edge therefore suppresses the access completely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      rf_address <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= 2'b00;
      tmo_cnt    <= '0;
      drop       <= 1'b0;
    end else begin
      rf_wr_en  <= 1'b0;
      rf_rd_en  <= 1'b0;
      err_valid <= 1'b0;
      tmo_cnt   <= '0;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_WR) begin
              state <= WR_ADDR;
              busy  <= 1'b1;
            end else if (rx_data == CMD_RD) begin
              state <= RD_ADDR;
              busy  <= 1'b1;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_OPCODE;
            end
          end
        end

        WR_ADDR: begin
          if (rx_valid) begin
            rf_address <= rx_data[ADDR-1:0];
            drop       <= addr_bad;
            state      <= WR_DATA;
          end else if (tmo_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        WR_DATA: begin
          if (rx_valid) begin
            rf_wr_data <= rx_data;
            state      <= WR_EXEC;
          end else if (tmo_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            drop      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        WR_EXEC: begin
          if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (drop) begin
            err_valid <= 1'b1;
            err_code  <= ERR_ADDRESS;
          end else begin
            rf_wr_en <= 1'b1;
          end
          drop  <= 1'b0;
          state <= IDLE;
          busy  <= 1'b0;
        end

        RD_ADDR: begin
          if (rx_valid) begin
            if (addr_bad) begin
              state     <= IDLE;
              busy      <= 1'b0;
              err_valid <= 1'b1;
              err_code  <= ERR_ADDRESS;
            end else begin
              rf_address <= rx_data[ADDR-1:0];
              state      <= RD_REQ;
            end
          end else if (tmo_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RD_REQ: begin
          if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          rf_rd_en <= 1'b1;
          state    <= RD_WAIT;
        end

        // While rf_rd_en is still high, the register file has not yet
        // sampled the request. Any valid seen then belongs to an older read.
        RD_WAIT: begin
          if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (rf_rd_valid && !rf_rd_en) begin
            tx_data  <= rf_rd_data;
            tx_valid <= 1'b1;
            state    <= TX;
          end else if (tmo_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        TX: begin
          if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_cmd_ctrl
//
// Directed bench for regfile_cmd_ctrl. A small behavioural register file with
// known reset contents answers read requests one edge after rf_rd_en. It keeps
// rf_rd_valid high once set, so that a stale valid is present on later reads.
// Each scenario task drives byte frames and compares DUT outputs against
// hand-computed values. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_cmd_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int ADDR    = 4;
  localparam int TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [ADDR-1:0]  rf_address;
  logic [WIDTH-1:0] rf_wr_data;
  logic             rf_wr_en;
  logic             rf_rd_en;
  logic [WIDTH-1:0] rf_rd_data;
  logic             rf_rd_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             err_valid;
  logic [1:0]       err_code;

  int checks = 0;
  int fails  = 0;

  int         wr_pulses  = 0;
  int         rd_pulses  = 0;
  int         err_pulses = 0;
  int         both_high  = 0;
  logic [1:0] last_err   = 2'b00;

  logic [WIDTH-1:0] rf_mem [DEPTH];

  always #5 clk = ~clk;

  regfile_cmd_ctrl #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR   (ADDR),
    .TIMEOUT(TIMEOUT),
    .CMD_WR (8'hAA),
    .CMD_RD (8'hBB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rf_address (rf_address),
    .rf_wr_data (rf_wr_data),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_data (rf_rd_data),
    .rf_rd_valid(rf_rd_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .err_valid  (err_valid),
    .err_code   (err_code)
  );

  // Reset contents of the register-file model
  function automatic logic [WIDTH-1:0] rf_init(input int idx);
    case (idx)
      0:       return 8'h00;
      1:       return 8'h5A;
      2:       return 8'h81;
      3:       return 8'h20;
      4:       return 8'h33;
      5:       return 8'h44;
      6:       return 8'h55;
      default: return 8'h66;
    endcase
  endfunction

  // Registered register-file model: data and valid update on the same edge
  // as the sampled rf_rd_en; valid then stays high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf_mem[i] <= rf_init(i);
      rf_rd_data  <= '0;
      rf_rd_valid <= 1'b0;
    end else begin
      if (rf_wr_en) rf_mem[rf_address[2:0]] <= rf_wr_data;
      if (rf_rd_en) begin
        rf_rd_data  <= rf_mem[rf_address[2:0]];
        rf_rd_valid <= 1'b1;
      end
    end
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (rf_wr_en) wr_pulses <= wr_pulses + 1;
    if (rf_rd_en) rd_pulses <= rd_pulses + 1;
    if (rf_wr_en && rf_rd_en) both_high <= both_high + 1;
    if (err_valid) begin
      err_pulses <= err_pulses + 1;
      last_err   <= err_code;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [WIDTH-1:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({rf_address, rf_wr_data, rf_wr_en, rf_rd_en, tx_data, tx_valid, busy, err_valid, err_code} !== 27'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {rf_address, rf_wr_data, rf_wr_en, rf_rd_en, tx_data, tx_valid, busy, err_valid, err_code});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int w0;
    int e0;
    w0 = wr_pulses;
    e0 = err_pulses;
    send_byte(8'hAA);
    tick();
    send_byte(8'h05);
    tick();
    send_byte(8'h3C);
    checks++;
    if (rf_wr_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL write_exec_cycle: got wr_en=%b busy=%b expected wr_en=0 busy=1", rf_wr_en, busy);
    end
    tick();
    checks++;
    if (rf_wr_en !== 1'b1 || rf_address !== 4'd5 || rf_wr_data !== 8'h3C) begin
      fails++;
      $display("[TB] FAIL write_pulse: got en=%b addr=%h data=%h expected en=1 addr=5 data=3c",
               rf_wr_en, rf_address, rf_wr_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL write_busy_idle: got %b expected 0", busy);
    end
    tick();
    checks++;
    if (rf_wr_en !== 1'b0 || wr_pulses - w0 !== 1) begin
      fails++;
      $display("[TB] FAIL write_single_pulse: got en=%b pulses=%0d expected en=0 pulses=1", rf_wr_en, wr_pulses - w0);
    end
    checks++;
    if (err_pulses - e0 !== 0) begin
      fails++;
      $display("[TB] FAIL write_no_error: got %0d error pulses expected 0", err_pulses - e0);
    end
  endtask

  task automatic test_read();
    int r0;
    r0 = rd_pulses;
    tx_ready = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h02);
    checks++;
    if (rf_rd_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_req_early: got rd_en=%b expected 0", rf_rd_en);
    end
    tick();
    checks++;
    if (rf_rd_en !== 1'b1 || rf_address !== 4'd2) begin
      fails++;
      $display("[TB] FAIL read_req: got rd_en=%b addr=%h expected rd_en=1 addr=2", rf_rd_en, rf_address);
    end
    tick();
    checks++;
    if (rf_rd_en !== 1'b0 || tx_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_wait: got rd_en=%b tx_valid=%b expected 0 0", rf_rd_en, tx_valid);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h81) begin
      fails++;
      $display("[TB] FAIL read_tx: got valid=%b data=%h expected valid=1 data=81", tx_valid, tx_data);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || rd_pulses - r0 !== 1) begin
      fails++;
      $display("[TB] FAIL read_done: got valid=%b busy=%b rd_pulses=%0d expected 0 0 1",
               tx_valid, busy, rd_pulses - r0);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int   e0;
    logic stable;
    e0 = err_pulses;
    tx_ready = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h03);
    tick();
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h20) begin
      fails++;
      $display("[TB] FAIL bp_tx_start: got valid=%b data=%h expected valid=1 data=20", tx_valid, tx_data);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        rx_data  = 8'h55;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (tx_valid !== 1'b1 || tx_data !== 8'h20 || busy !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp_hold: got stable=%b expected 1", stable);
    end
    checks++;
    if (err_pulses - e0 !== 1 || last_err !== 2'b00) begin
      fails++;
      $display("[TB] FAIL bp_overrun: got pulses=%0d code=%b expected pulses=1 code=00", err_pulses - e0, last_err);
    end
    tx_ready = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_handshake: got valid=%b busy=%b expected 0 0", tx_valid, busy);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_errors();
    int w0;
    int r0;
    w0 = wr_pulses;
    r0 = rd_pulses;
    send_byte(8'h12);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bad_opcode: got err=%b code=%b busy=%b expected 1 01 0", err_valid, err_code, busy);
    end
    send_byte(8'hAA);
    send_byte(8'h09);
    send_byte(8'hFF);
    tick();
    checks++;
    if (err_valid !== 1'b1 || err_code !== 2'b10 || rf_wr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bad_wr_addr: got err=%b code=%b wr_en=%b busy=%b expected 1 10 0 0",
               err_valid, err_code, rf_wr_en, busy);
    end
    send_byte(8'hBB);
    send_byte(8'h08);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bad_rd_addr: got err=%b code=%b busy=%b expected 1 10 0", err_valid, err_code, busy);
    end
    tick();
    tick();
    checks++;
    if (wr_pulses - w0 !== 0 || rd_pulses - r0 !== 0) begin
      fails++;
      $display("[TB] FAIL bad_addr_no_access: got wr=%0d rd=%0d expected 0 0", wr_pulses - w0, rd_pulses - r0);
    end
  endtask

  task automatic test_timeout();
    logic early;
    send_byte(8'hAA);
    send_byte(8'h04);
    early = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      if (err_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_early: got early=%b expected 0", early);
    end
    tick();
    checks++;
    if (err_valid !== 1'b1 || err_code !== 2'b11 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_fire: got err=%b code=%b busy=%b expected 1 11 0", err_valid, err_code, busy);
    end
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h77);
    tick();
    checks++;
    if (rf_wr_en !== 1'b1 || rf_address !== 4'd1 || rf_wr_data !== 8'h77) begin
      fails++;
      $display("[TB] FAIL timeout_recover: got en=%b addr=%h data=%h expected 1 1 77", rf_wr_en, rf_address, rf_wr_data);
    end
    tick();
    tx_ready = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h01);
    tick();
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      fails++;
      $display("[TB] FAIL readback: got valid=%b data=%h expected 1 77", tx_valid, tx_data);
    end
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int w0;
    w0 = wr_pulses;
    send_byte(8'hAA);
    send_byte(8'h06);
    send_byte(8'h99);
    rst = 1'b1;
    tick();
    checks++;
    if ({rf_address, rf_wr_data, rf_wr_en, rf_rd_en, tx_data, tx_valid, busy, err_valid, err_code} !== 27'd0) begin
      fails++;
      $display("[TB] FAIL midframe_reset_outputs: got %h expected 0",
               {rf_address, rf_wr_data, rf_wr_en, rf_rd_en, tx_data, tx_valid, busy, err_valid, err_code});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (wr_pulses - w0 !== 0) begin
      fails++;
      $display("[TB] FAIL midframe_no_write: got %0d write pulses expected 0", wr_pulses - w0);
    end
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h3E);
    tick();
    checks++;
    if (rf_wr_en !== 1'b1 || rf_address !== 4'd7 || rf_wr_data !== 8'h3E) begin
      fails++;
      $display("[TB] FAIL midframe_recover: got en=%b addr=%h data=%h expected 1 7 3e", rf_wr_en, rf_address, rf_wr_data);
    end
    tick();
    checks++;
    if (both_high !== 0) begin
      fails++;
      $display("[TB] FAIL enables_exclusive: got %0d overlapping cycles expected 0", both_high);
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_errors();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
